// File: rtl/hamming_pkg.sv
// Shared types, bit-position masks, FSM states and Hamming(12,8) helpers
// for the stripe corrector. Vector index i holds Hamming position i+1.
package hamming_pkg;

  localparam int CW_W = 12;
  localparam int SY_W = 4;

  typedef logic [CW_W-1:0] codeword_t;
  typedef logic [SY_W-1:0] syndrome_t;

  // Parity bits sit at indices 0, 1, 3, 7; the decoder extracts the rest.
  localparam codeword_t PARITY_IDX = 12'b0000_1000_1011;
  localparam codeword_t DATA_IDX   = 12'b1111_0111_0100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYND  = 3'd1,
    ST_FIX   = 3'd2,
    ST_EMIT0 = 3'd3,
    ST_EMIT1 = 3'd4
  } stripe_state_t;

  // Syndrome bit k is the XOR of every bit whose position has bit k set.
  function automatic syndrome_t calc_syndrome(input codeword_t cw);
    syndrome_t s;
    logic [3:0] pos;
    s = 4'd0;
    for (int i = 0; i < CW_W; i++) begin
      pos = 4'(i + 1);
      for (int k = 0; k < SY_W; k++) begin
        s[k] = s[k] ^ (cw[i] & pos[k]);
      end
    end
    return s;
  endfunction

  // Syndromes 1..12 point at a real bit position and can be repaired.
  function automatic logic is_correctable(input syndrome_t s);
    return (s != 4'd0) && (s <= 4'd12);
  endfunction

  // Syndromes 13..15 point past the end of the codeword.
  function automatic logic is_uncorrectable(input syndrome_t s);
    return (s >= 4'd13);
  endfunction

  // Flip the bit the syndrome names; anything else passes through.
  function automatic codeword_t flip_bit(input codeword_t cw, input syndrome_t s);
    codeword_t mask;
    mask = 12'd1 << (s - 4'd1);
    return is_correctable(s) ? (cw ^ mask) : cw;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming(12,8) syndrome of one codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  codeword_t cw,
  output syndrome_t synd
);

  assign synd = calc_syndrome(cw);

endmodule

// File: rtl/hamming_stripe_corrector.sv
// Stripe read-path corrector: computes syndromes for D0, D1 and P, repairs
// single-bit errors, rebuilds one lost data word from the other plus parity,
// then emits D0 and D1 serially and keeps saturating error statistics.
module hamming_stripe_corrector
  import hamming_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_d0,
  input  logic [11:0] in_d1,
  input  logic [11:0] in_p,
  input  logic        cnt_clr,
  output logic        out_valid,
  output logic        out_blk,
  output logic [11:0] out_data,
  output logic        out_sel_blk,
  output logic [3:0]  out_synd,
  output logic        out_err,
  output logic [15:0] cnt_corrected,
  output logic [15:0] cnt_rebuilt,
  output logic [15:0] cnt_fail
);

  // Saturating add of a small increment to a 16-bit statistic.
  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, c} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  stripe_state_t state_q, state_d;
  codeword_t cap_d0_q, cap_d0_d, cap_d1_q, cap_d1_d, cap_p_q, cap_p_d;
  syndrome_t s0_q, s0_d, s1_q, s1_d, sp_q, sp_d;
  codeword_t fin_d1_q, fin_d1_d;
  logic      sel1_q, sel1_d, err_q, err_d;
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d, out_blk_q, out_blk_d;
  logic [11:0] out_data_q, out_data_d;
  logic        out_sel_q, out_sel_d, out_err_q, out_err_d;
  logic [3:0]  out_synd_q, out_synd_d;
  logic [15:0] cnt_cor_q, cnt_cor_d, cnt_reb_q, cnt_reb_d, cnt_fail_q, cnt_fail_d;

  syndrome_t syn0_s, syn1_s, synp_s;
  codeword_t c0_s, c1_s, cp_s, fin0_s, fin1_s;
  logic      u0_s, u1_s, up_s, fail_s, reb0_s, reb1_s, sel0_s, sel1_s;
  logic [1:0] cor_cnt_s;

  hamming_syndrome u_syn_d0 (.cw(cap_d0_q), .synd(syn0_s));
  hamming_syndrome u_syn_d1 (.cw(cap_d1_q), .synd(syn1_s));
  hamming_syndrome u_syn_p  (.cw(cap_p_q),  .synd(synp_s));

  // Correction / rebuild datapath evaluated from the registered syndromes.
  always_comb begin
    c0_s   = flip_bit(cap_d0_q, s0_q);
    c1_s   = flip_bit(cap_d1_q, s1_q);
    cp_s   = flip_bit(cap_p_q, sp_q);
    u0_s   = is_uncorrectable(s0_q);
    u1_s   = is_uncorrectable(s1_q);
    up_s   = is_uncorrectable(sp_q);
    fail_s = (u0_s & u1_s) | ((u0_s | u1_s) & up_s);
    reb0_s = u0_s & ~u1_s & ~up_s;
    reb1_s = u1_s & ~u0_s & ~up_s;
    if (fail_s) begin
      fin0_s = cap_d0_q;
      fin1_s = cap_d1_q;
    end else begin
      fin0_s = reb0_s ? (c1_s ^ cp_s) : c0_s;
      fin1_s = reb1_s ? (c0_s ^ cp_s) : c1_s;
    end
    sel0_s    = ~fail_s & (reb0_s | is_correctable(s0_q));
    sel1_s    = ~fail_s & (reb1_s | is_correctable(s1_q));
    cor_cnt_s = {1'b0, is_correctable(s0_q)} + {1'b0, is_correctable(s1_q)}
              + {1'b0, is_correctable(sp_q)};
  end

  // Next-state, output and counter logic for the stripe sequencer.
  always_comb begin
    state_d     = state_q;
    cap_d0_d    = cap_d0_q;
    cap_d1_d    = cap_d1_q;
    cap_p_d     = cap_p_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    sp_d        = sp_q;
    fin_d1_d    = fin_d1_q;
    sel1_d      = sel1_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    out_blk_d   = out_blk_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_synd_d  = out_synd_q;
    out_err_d   = out_err_q;
    cnt_cor_d   = cnt_cor_q;
    cnt_reb_d   = cnt_reb_q;
    cnt_fail_d  = cnt_fail_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cap_d0_d = in_d0;
          cap_d1_d = in_d1;
          cap_p_d  = in_p;
          state_d  = ST_SYND;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SYND: begin
        s0_d    = syn0_s;
        s1_d    = syn1_s;
        sp_d    = synp_s;
        state_d = ST_FIX;
      end
      ST_FIX: begin
        out_valid_d = 1'b1;
        out_blk_d   = 1'b0;
        out_data_d  = fin0_s;
        out_sel_d   = sel0_s;
        out_synd_d  = s0_q;
        out_err_d   = fail_s;
        fin_d1_d    = fin1_s;
        sel1_d      = sel1_s;
        err_d       = fail_s;
        cnt_cor_d   = sat_add(cnt_cor_q, cor_cnt_s);
        cnt_reb_d   = sat_add(cnt_reb_q, {1'b0, reb0_s | reb1_s} & {2{~fail_s}});
        cnt_fail_d  = sat_add(cnt_fail_q, {1'b0, fail_s});
        state_d     = ST_EMIT0;
      end
      ST_EMIT0: begin
        out_valid_d = 1'b1;
        out_blk_d   = 1'b1;
        out_data_d  = fin_d1_q;
        out_sel_d   = sel1_q;
        out_synd_d  = s1_q;
        out_err_d   = err_q;
        state_d     = ST_EMIT1;
      end
      ST_EMIT1: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
    if (cnt_clr) begin
      cnt_cor_d  = 16'd0;
      cnt_reb_d  = 16'd0;
      cnt_fail_d = 16'd0;
    end else begin
      cnt_cor_d  = cnt_cor_d;
    end
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cap_d0_q    <= 12'd0;
      cap_d1_q    <= 12'd0;
      cap_p_q     <= 12'd0;
      s0_q        <= 4'd0;
      s1_q        <= 4'd0;
      sp_q        <= 4'd0;
      fin_d1_q    <= 12'd0;
      sel1_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_blk_q   <= 1'b0;
      out_data_q  <= 12'd0;
      out_sel_q   <= 1'b0;
      out_synd_q  <= 4'd0;
      out_err_q   <= 1'b0;
      cnt_cor_q   <= 16'd0;
      cnt_reb_q   <= 16'd0;
      cnt_fail_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cap_d0_q    <= cap_d0_d;
      cap_d1_q    <= cap_d1_d;
      cap_p_q     <= cap_p_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      sp_q        <= sp_d;
      fin_d1_q    <= fin_d1_d;
      sel1_q      <= sel1_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_blk_q   <= out_blk_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_synd_q  <= out_synd_d;
      out_err_q   <= out_err_d;
      cnt_cor_q   <= cnt_cor_d;
      cnt_reb_q   <= cnt_reb_d;
      cnt_fail_q  <= cnt_fail_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_blk       = out_blk_q;
  assign out_data      = out_data_q;
  assign out_sel_blk   = out_sel_q;
  assign out_synd      = out_synd_q;
  assign out_err       = out_err_q;
  assign cnt_corrected = cnt_cor_q;
  assign cnt_rebuilt   = cnt_reb_q;
  assign cnt_fail      = cnt_fail_q;

endmodule

// File: tb/tb_hamming_stripe_corrector.sv
// Directed bench for hamming_stripe_corrector with a scoreboard of expected
// emissions built from an independent Hamming model at each accepted stripe.
module tb_hamming_stripe_corrector;

  logic        clk, reset, in_valid, in_ready, cnt_clr;
  logic [11:0] in_d0, in_d1, in_p, out_data;
  logic        out_valid, out_blk, out_sel_blk, out_err;
  logic [3:0]  out_synd;
  logic [15:0] cnt_corrected, cnt_rebuilt, cnt_fail;

  hamming_stripe_corrector dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_d0(in_d0), .in_d1(in_d1), .in_p(in_p), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_blk(out_blk), .out_data(out_data),
    .out_sel_blk(out_sel_blk), .out_synd(out_synd), .out_err(out_err),
    .cnt_corrected(cnt_corrected), .cnt_rebuilt(cnt_rebuilt), .cnt_fail(cnt_fail)
  );

  typedef struct {
    logic        blk;
    logic [11:0] data;
    logic        sel;
    logic [3:0]  synd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   passed, total, cyc, last_acc;
  logic cont_mode;
  logic [11:0] a, b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
  endtask

  // Syndrome as XOR of the positions of all set bits.
  function automatic logic [3:0] tb_synd(input logic [11:0] cw);
    logic [3:0] s;
    s = 4'd0;
    for (int pos = 1; pos <= 12; pos++)
      if (cw[pos-1]) s = s ^ 4'(pos);
    return s;
  endfunction

  // Place 8 data bits at non-power-of-two positions and fill parity.
  function automatic logic [11:0] enc(input logic [7:0] d);
    logic [11:0] cw;
    logic [3:0]  s;
    int j;
    cw = 12'd0;
    j  = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
        cw[pos-1] = d[j];
        j++;
      end
    end
    s = tb_synd(cw);
    cw[0] = s[0];
    cw[1] = s[1];
    cw[3] = s[2];
    cw[7] = s[3];
    return cw;
  endfunction

  function automatic logic [11:0] fixw(input logic [11:0] cw, input logic [3:0] s);
    return (s >= 4'd1 && s <= 4'd12) ? (cw ^ (12'd1 << (s - 4'd1))) : cw;
  endfunction

  function automatic void push_exp(input logic [11:0] d0, input logic [11:0] d1,
                                   input logic [11:0] p);
    logic [3:0]  s0, s1, sp;
    logic [11:0] c0, c1, cp;
    logic        u0, u1, up, fl;
    exp_t e0, e1;
    s0 = tb_synd(d0); s1 = tb_synd(d1); sp = tb_synd(p);
    c0 = fixw(d0, s0); c1 = fixw(d1, s1); cp = fixw(p, sp);
    u0 = (s0 >= 4'd13); u1 = (s1 >= 4'd13); up = (sp >= 4'd13);
    fl = (u0 && u1) || ((u0 || u1) && up);
    e0.blk = 1'b0; e0.synd = s0; e0.err = fl; e0.cyc = cyc + 2;
    e1.blk = 1'b1; e1.synd = s1; e1.err = fl; e1.cyc = cyc + 3;
    if (fl) begin
      e0.data = d0; e0.sel = 1'b0;
      e1.data = d1; e1.sel = 1'b0;
    end else begin
      e0.data = u0 ? (c1 ^ cp) : c0; e0.sel = u0 || (s0 != 4'd0);
      e1.data = u1 ? (c0 ^ cp) : c1; e1.sel = u1 || (s1 != 4'd0);
    end
    exp_q.push_back(e0);
    exp_q.push_back(e1);
  endfunction

  // Scoreboard: record accepted stripes, check each emitted codeword.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!reset && in_valid && in_ready) begin
      push_exp(in_d0, in_d1, in_p);
      if (cont_mode) begin
        if (last_acc >= 0) chk("accept_gap", cyc - last_acc, 5);
        last_acc = cyc;
      end
    end
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_blk", {31'd0, out_blk}, {31'd0, e.blk});
        chk("out_data", {20'd0, out_data}, {20'd0, e.data});
        chk("out_sel_blk", {31'd0, out_sel_blk}, {31'd0, e.sel});
        chk("out_synd", {28'd0, out_synd}, {28'd0, e.synd});
        chk("out_err", {31'd0, out_err}, {31'd0, e.err});
        chk("out_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] p);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_d0 = d0; in_d1 = d1; in_p = p;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] c, input logic [15:0] r,
                         input logic [15:0] f);
    chk({tag, "_corrected"}, {16'd0, cnt_corrected}, {16'd0, c});
    chk({tag, "_rebuilt"}, {16'd0, cnt_rebuilt}, {16'd0, r});
    chk({tag, "_fail"}, {16'd0, cnt_fail}, {16'd0, f});
  endtask

  initial begin
    passed = 0; total = 0; cyc = 0; last_acc = -1; cont_mode = 1'b0;
    reset = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;
    in_d0 = 12'd0; in_d1 = 12'd0; in_p = 12'd0;
    a = enc(8'hA5);
    b = enc(8'h3C);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_blk", {31'd0, out_blk}, 32'd0);
    chk("rst_out_data", {20'd0, out_data}, 32'd0);
    chk("rst_out_sel", {31'd0, out_sel_blk}, 32'd0);
    chk("rst_out_synd", {28'd0, out_synd}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk_cnt("rst", 16'd0, 16'd0, 16'd0);
    reset = 1'b0;
    @(negedge clk);

    // Clean stripe: all three codewords valid.
    send(12'h000, b, b);
    drain();
    chk_cnt("clean", 16'd0, 16'd0, 16'd0);

    // Single-bit error at index 4 of D0 (syndrome 5).
    send(a ^ 12'h010, b, a ^ b);
    drain();
    chk_cnt("single", 16'd1, 16'd0, 16'd0);

    // D1 with syndrome 13 (positions 1 and 12 flipped) rebuilt from D0 ^ P.
    send(a, b ^ 12'h801, a ^ b);
    drain();
    chk_cnt("rebuild", 16'd1, 16'd1, 16'd0);

    // Both data words uncorrectable.
    send(a ^ 12'h801, b ^ 12'h801, a ^ b);
    drain();
    chk_cnt("fail", 16'd1, 16'd1, 16'd1);

    // Parity alone uncorrectable: normal emission, no failure.
    send(a, b, (a ^ b) ^ 12'h801);
    drain();
    chk_cnt("p_bad", 16'd1, 16'd1, 16'd1);

    // Continuous in_valid: accepts spaced five cycles apart.
    cont_mode = 1'b1; last_acc = -1;
    in_valid = 1'b1; in_d0 = a; in_d1 = b; in_p = a ^ b;
    repeat (16) @(negedge clk);
    in_valid = 1'b0; cont_mode = 1'b0;
    drain();
    chk("cont_accepts_seen", {31'd0, last_acc > 0}, 32'd1);

    // Reset while in SYND drops the stripe.
    send(a ^ 12'h010, b, a ^ b);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("rst_synd_out_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_synd_in_ready", {31'd0, in_ready}, 32'd1);
    drain();
    chk("rst_synd_quiet", {31'd0, out_valid}, 32'd0);
    chk_cnt("post_rst", 16'd0, 16'd0, 16'd0);

    // Saturation of cnt_corrected.
    force dut.cnt_cor_q = 16'hFFFD;
    @(negedge clk);
    release dut.cnt_cor_q;
    @(negedge clk);
    chk("preload", {16'd0, cnt_corrected}, 32'h0000FFFD);
    send(a ^ 12'h010, b ^ 12'h020, a ^ b);
    drain();
    chk("sat_reach", {16'd0, cnt_corrected}, 32'h0000FFFF);
    send(a ^ 12'h010, b ^ 12'h020, (a ^ b) ^ 12'h001);
    drain();
    chk("sat_hold", {16'd0, cnt_corrected}, 32'h0000FFFF);

    // cnt_clr in the FIX cycle wins over correction and rebuild increments.
    send(a ^ 12'h010, b ^ 12'h801, a ^ b);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    drain();
    chk_cnt("clr", 16'd0, 16'd0, 16'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
